// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching interrupt controller with per-line mask, global
// enable, fixed lowest-index priority and a request/ack/EOI CPU handshake.
// Software access goes through the shared cs_/as_/rw/addr slave bus.
module irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_,
  input  logic               as_,
  input  logic               rw,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               rdy_,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_irq_id,
  input  logic               cpu_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  state_t             state, state_nxt;
  logic               enable;
  logic [NUM_IRQ-1:0] mask, pend, irq_d;
  logic [ID_W-1:0]    cur_id;

  logic               access, bus_wr, bus_rd;
  logic               wr_ctrl, wr_mask, wr_pend, eoi;
  logic [NUM_IRQ-1:0] rise, req_vec, cur_oh, clr_vec;
  logic               win_vld, cur_ok, ack_clr;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        rd_mux;

  // bus decode
  assign access  = !cs_ && !as_;
  assign bus_wr  = access && !rw;
  assign bus_rd  = access && rw;
  assign wr_ctrl = bus_wr && (addr == A_CTRL);
  assign wr_mask = bus_wr && (addr == A_MASK);
  assign wr_pend = bus_wr && (addr == A_PEND);
  assign eoi     = bus_wr && (addr == A_STAT);

  // rising edges only, so a line held high fires once
  assign rise    = irq_in & ~irq_d;
  assign req_vec = enable ? (pend & mask) : '0;
  assign cur_oh  = NUM_IRQ'(1) << cur_id;
  // the in-flight request stays valid only while its line is still deliverable
  assign cur_ok  = enable && |(mask & pend & cur_oh);

  // lowest index wins: scan downward so the last hit is the smallest index
  always_comb begin
    win_vld = |req_vec;
    win_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req_vec[i]) win_id = ID_W'(i);
  end

  // handshake next-state; ack takes precedence over withdrawal in REQ
  always_comb begin
    state_nxt = state;
    ack_clr   = 1'b0;
    case (state)
      IDLE: if (win_vld) state_nxt = REQ;
      REQ: begin
        if (cpu_ack) begin
          state_nxt = SERV;
          ack_clr   = 1'b1;
        end else if (!cur_ok) begin
          state_nxt = IDLE;
        end
      end
      SERV:    if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pending clears from software W1C and from the CPU ack of the current id
  always_comb begin
    clr_vec = '0;
    if (wr_pend) clr_vec = clr_vec | wr_data[NUM_IRQ-1:0];
    if (ack_clr) clr_vec = clr_vec | cur_oh;
  end

  // register read mux
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL: rd_mux[0] = enable;
      A_MASK: rd_mux[NUM_IRQ-1:0] = mask;
      A_PEND: rd_mux[NUM_IRQ-1:0] = pend;
      A_STAT: begin
        rd_mux[9:8]      = state;
        rd_mux[ID_W-1:0] = cur_id;
      end
      default: rd_mux = '0;
    endcase
  end

  // bus response: ready and read data both one cycle after the access
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_    <= 1'b1;
      rd_data <= '0;
    end else begin
      rdy_    <= !access;
      rd_data <= bus_rd ? rd_mux : 32'd0;
    end
  end

  // software-visible configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      mask   <= '0;
    end else begin
      if (wr_ctrl) enable <= wr_data[0];
      if (wr_mask) mask   <= wr_data[NUM_IRQ-1:0];
    end
  end

  // edge capture; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d <= '0;
      pend  <= '0;
    end else begin
      irq_d <= irq_in;
      pend  <= (pend & ~clr_vec) | rise;
    end
  end

  // FSM state plus the registered CPU-facing request
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_id     <= '0;
      cpu_irq    <= 1'b0;
      cpu_irq_id <= '0;
    end else begin
      state   <= state_nxt;
      cpu_irq <= (state_nxt == REQ);
      if (state == IDLE && win_vld) begin
        cur_id     <= win_id;
        cpu_irq_id <= win_id;
      end
    end
  end

endmodule
